fx2_slavefifo_bridge: RTL and testbench

- Parametrised next-generation FX2LP synchronous slave-FIFO loopback engine.
- Drains the host OUT endpoint into an internal circular buffer, then writes the buffer back to the host IN endpoint.
- Adds configurable bus width, buffer depth and endpoint addresses, plus a PKTEND short-packet commit after an idle timeout.
- Sits between the board top-level pin tristates and the FX2LP FLAG/control pins, clocked by fx2_IFCLK.

---
 rtl/fx2_slavefifo_bridge.sv | 144 ++++++++++++++
 tb/tb_fx2_slavefifo_bridge.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slavefifo_bridge.sv
// FX2LP slave-FIFO loopback: drains OUT endpoint into a circular buffer, writes it back to IN; PKTEND on idle timeout.
// Zero-latency strobes gated combinationally by FLAGA/FLAGD and buffer full/empty; one-cycle turnaround before writes.
module fx2_slavefifo_bridge #(
    parameter int          DATA_W         = 16,
    parameter int          FIFO_DEPTH     = 512,
    parameter logic [1:0]  RD_EP_ADDR     = 2'b00,
    parameter logic [1:0]  WR_EP_ADDR     = 2'b10,
    parameter int          PKT_WORDS      = 256,
    parameter int          PKTEND_TIMEOUT = 1024
) (
    input  logic                        fx2_IFCLK,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           fd_in,
    output logic [DATA_W-1:0]           fd_out,
    output logic                        fd_oe,
    input  logic                        flag_empty_n,
    input  logic                        flag_full_n,
    output logic [1:0]                  fifoadr,
    output logic                        sloe_n,
    output logic                        slrd_n,
    output logic                        slwr_n,
    output logic                        pktend_n,
    output logic [$clog2(FIFO_DEPTH):0] buf_level,
    output logic                        buf_empty,
    output logic                        buf_full,
    output logic [15:0]                 commit_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PKT_WORDS) + 1;
    localparam int IW = (PKTEND_TIMEOUT > 1) ? $clog2(PKTEND_TIMEOUT) : 1;
    localparam bit PE_EN = (PKTEND_TIMEOUT != 0);
    localparam logic [IW-1:0] IDLE_MAX = IW'((PKTEND_TIMEOUT > 0) ? PKTEND_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_TURN, S_WRITE, S_PKTEND} state_t;

    state_t            state, state_nxt;
    logic              mark, mark_nxt;
    logic              push, pop;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [PW-1:0]     pkt_cnt;
    logic [IW-1:0]     idle_cnt;
    logic              can_rd, can_wr, timeout_hit;

    assign buf_empty   = (buf_level == '0);
    assign buf_full    = (buf_level == LW'(FIFO_DEPTH));
    assign can_rd      = flag_empty_n && !buf_full;
    assign can_wr      = flag_full_n && !buf_empty;
    assign timeout_hit = PE_EN && buf_empty && (pkt_cnt != '0) && (idle_cnt == IDLE_MAX) && flag_full_n;

    always_comb begin
        state_nxt = state;
        mark_nxt  = mark;
        fifoadr   = RD_EP_ADDR;
        sloe_n    = 1'b1;
        slrd_n    = 1'b1;
        slwr_n    = 1'b1;
        pktend_n  = 1'b1;
        fd_oe     = 1'b0;
        fd_out    = '0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (can_rd) begin
                    state_nxt = S_READ;
                end else if (!buf_empty && flag_full_n) begin
                    state_nxt = S_TURN;
                end else if (timeout_hit) begin
                    state_nxt = S_TURN;
                    mark_nxt  = 1'b1;
                end
            end
            S_READ: begin
                if (can_rd) begin
                    sloe_n = 1'b0;
                    slrd_n = 1'b0;
                    push   = 1'b1;
                end else begin
                    state_nxt = buf_empty ? S_IDLE : S_TURN;
                end
            end
            S_TURN: begin
                fifoadr   = WR_EP_ADDR;
                mark_nxt  = 1'b0;
                state_nxt = mark ? S_PKTEND : S_WRITE;
            end
            S_WRITE: begin
                fifoadr = WR_EP_ADDR;
                fd_oe   = 1'b1;
                fd_out  = mem[rd_ptr];
                if (can_wr) begin
                    slwr_n = 1'b0;
                    pop    = 1'b1;
                    // Leave as the last word goes so fd_oe drops in the very next cycle.
                    if (buf_level == LW'(1)) state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_PKTEND: begin
                fifoadr   = WR_EP_ADDR;
                pktend_n  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fx2_IFCLK or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mark       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            buf_level  <= '0;
            pkt_cnt    <= '0;
            idle_cnt   <= '0;
            commit_cnt <= '0;
        end else begin
            state <= state_nxt;
            mark  <= mark_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push)     buf_level <= buf_level + 1'b1;
            else if (pop) buf_level <= buf_level - 1'b1;

            if (pop)                   pkt_cnt <= (pkt_cnt == PW'(PKT_WORDS - 1)) ? '0 : pkt_cnt + 1'b1;
            else if (state == S_PKTEND) pkt_cnt <= '0;

            if (state == S_PKTEND) commit_cnt <= commit_cnt + 1'b1;

            if (push || pop || state == S_PKTEND)
                idle_cnt <= '0;
            else if (state == S_IDLE && buf_empty && pkt_cnt != '0 && idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge fx2_IFCLK) begin
        if (push) mem[wr_ptr] <= fd_in;
    end
endmodule

// File: tb/tb_fx2_slavefifo_bridge.sv
// Bench for fx2_slavefifo_bridge: behavioural FX2 endpoints plus a write-data scoreboard.
module tb_fx2_slavefifo_bridge;
    localparam int INF = 1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] fd_in = '0;
    logic [15:0] fd_out;
    logic        fd_oe;
    logic        flag_empty_n = 1'b0;
    logic        flag_full_n = 1'b0;
    logic [1:0]  fifoadr;
    logic        sloe_n, slrd_n, slwr_n, pktend_n;
    logic [4:0]  buf_level;
    logic        buf_empty, buf_full;
    logic [15:0] commit_cnt;

    fx2_slavefifo_bridge #(
        .DATA_W(16), .FIFO_DEPTH(16), .RD_EP_ADDR(2'b00), .WR_EP_ADDR(2'b10),
        .PKT_WORDS(256), .PKTEND_TIMEOUT(64)
    ) dut (
        .fx2_IFCLK(clk), .rst(rst), .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
        .flag_empty_n(flag_empty_n), .flag_full_n(flag_full_n), .fifoadr(fifoadr),
        .sloe_n(sloe_n), .slrd_n(slrd_n), .slwr_n(slwr_n), .pktend_n(pktend_n),
        .buf_level(buf_level), .buf_empty(buf_empty), .buf_full(buf_full),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] host_out[$];
    logic [15:0] exp_q[$];
    int n_checks = 0, n_fail = 0;
    int in_credit = INF;
    int rd_cnt = 0, wr_cnt = 0, turn_cnt = 0, pktend_cnt = 0;
    int idle_run = 0, turn_idle_run = 0, pkt_idle_run = 0;
    int first_turn_rd = 0, first_turn_level = 0;
    bit first_turn_full = 0;
    bit prev_turn = 0, is_turn, is_idle;
    logic [15:0] exp_word;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] w);
        host_out.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_wr(input int n, input int budget, input string name);
        int i = 0;
        while (wr_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(wr_cnt == n, name, wr_cnt, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        host_out.delete();
        exp_q.delete();
        in_credit = INF;
        rd_cnt = 0; wr_cnt = 0; turn_cnt = 0; pktend_cnt = 0;
        idle_run = 0; turn_idle_run = 0; pkt_idle_run = 0; prev_turn = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // FX2 model: flags/data change after the falling edge; strobes are sampled just before the rising edge.
    always @(negedge clk) begin
        flag_empty_n = (host_out.size() != 0);
        fd_in        = (host_out.size() != 0) ? host_out[0] : 16'h0;
        flag_full_n  = (in_credit != 0);
        #4;
        if (!rst) begin
            if (!slrd_n) begin
                check(!buf_full, "push_when_full", buf_full, 0);
                check(flag_empty_n, "read_while_empty", flag_empty_n, 1);
                check(fifoadr == 2'b00, "read_fifoadr", fifoadr, 0);
                if (host_out.size() != 0) void'(host_out.pop_front());
                rd_cnt++;
            end
            if (!slwr_n) begin
                check(!buf_empty, "pop_when_empty", buf_empty, 0);
                check(flag_full_n, "write_while_full", flag_full_n, 1);
                check(fd_oe, "write_fd_oe", fd_oe, 1);
                check(fifoadr == 2'b10, "write_fifoadr", fifoadr, 2);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_write", fd_out, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check(fd_out == exp_word, "write_data", fd_out, exp_word);
                end
                wr_cnt++;
                if (in_credit > 0) in_credit--;
            end
            is_turn = (fifoadr == 2'b10) && !fd_oe && pktend_n && slwr_n;
            is_idle = (fifoadr == 2'b00) && slrd_n && sloe_n && slwr_n && pktend_n && !fd_oe;
            if (!pktend_n) begin
                pktend_cnt++;
                check(prev_turn, "pktend_after_turn", prev_turn, 1);
                check(!fd_oe && slwr_n, "pktend_bus_idle", {fd_oe, slwr_n}, 1);
                pkt_idle_run = turn_idle_run;
            end
            if (is_turn) begin
                if (turn_cnt == 0) begin
                    first_turn_full  = buf_full;
                    first_turn_level = int'(buf_level);
                    first_turn_rd    = rd_cnt;
                end
                turn_cnt++;
                turn_idle_run = idle_run;
            end
            idle_run  = is_idle ? idle_run + 1 : 0;
            prev_turn = is_turn;
        end
    end

    initial begin
        int base, i;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check({slrd_n, sloe_n, slwr_n, pktend_n} == 4'hF, "rst_strobes", {slrd_n, sloe_n, slwr_n, pktend_n}, 4'hF);
        check(fd_oe == 1'b0, "rst_fd_oe", fd_oe, 0);
        check(fd_out == 16'h0, "rst_fd_out", fd_out, 0);
        check(fifoadr == 2'b00, "rst_fifoadr", fifoadr, 0);
        check(buf_level == 5'd0 && buf_empty && !buf_full, "rst_buf", buf_level, 0);
        check(commit_cnt == 16'h0, "rst_commit", commit_cnt, 0);
        rst = 1'b0;

        // Single OUT packet
        do_reset();
        for (int w = 1; w <= 8; w++) send(16'(w));
        wait_wr(8, 200, "t1_writes");
        check(rd_cnt == 8, "t1_reads", rd_cnt, 8);
        check(turn_cnt == 1, "t1_turns", turn_cnt, 1);
        check(exp_q.size() == 0, "t1_drained", exp_q.size(), 0);

        // Buffer full and wrap
        do_reset();
        for (int w = 0; w < 20; w++) send(16'h1000 + 16'(w));
        wait_wr(20, 400, "t2_writes");
        check(first_turn_full, "t2_full_at_turn", first_turn_full, 1);
        check(first_turn_level == 16, "t2_level_at_turn", first_turn_level, 16);
        check(first_turn_rd == 16, "t2_reads_first_pass", first_turn_rd, 16);
        check(rd_cnt == 20, "t2_reads_total", rd_cnt, 20);
        check(turn_cnt == 2, "t2_turns", turn_cnt, 2);

        // IN endpoint backpressure
        do_reset();
        in_credit = 3;
        for (int w = 0; w < 10; w++) send(16'hA000 + 16'(w));
        wait_wr(3, 200, "t3_first_writes");
        repeat (5) @(negedge clk);
        #1;
        check(buf_level == 5'd7, "t3_level", buf_level, 7);
        check(!fd_oe && fifoadr == 2'b00, "t3_back_idle", {fd_oe, fifoadr}, 0);
        check(wr_cnt == 3, "t3_held", wr_cnt, 3);
        in_credit = INF;
        wait_wr(10, 200, "t3_all_writes");
        repeat (20) @(negedge clk);
        check(wr_cnt == 10, "t3_no_dup", wr_cnt, 10);
        check(exp_q.size() == 0, "t3_drained", exp_q.size(), 0);

        // PKTEND after idle timeout
        do_reset();
        for (int w = 0; w < 5; w++) send(16'h5A00 + 16'(w));
        wait_wr(5, 200, "t4_writes");
        i = 0;
        while (pktend_cnt == 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        #1;
        check(pktend_cnt == 1, "t4_pktend_once", pktend_cnt, 1);
        check(pkt_idle_run == 64, "t4_idle_cycles", pkt_idle_run, 64);
        check(commit_cnt == 16'd1, "t4_commit", commit_cnt, 1);
        repeat (200) @(negedge clk);
        #1;
        check(pktend_cnt == 1, "t4_pkt_cnt_cleared", pktend_cnt, 1);
        check(commit_cnt == 16'd1, "t4_commit_stable", commit_cnt, 1);

        // Exact full packet: auto-commit, no PKTEND
        do_reset();
        for (int w = 0; w < 256; w++) send(16'(w * 3 + 7));
        wait_wr(256, 3000, "t5_writes");
        repeat (200) @(negedge clk);
        #1;
        check(pktend_cnt == 0, "t5_no_pktend", pktend_cnt, 0);
        check(commit_cnt == 16'd0, "t5_commit", commit_cnt, 0);
        check(exp_q.size() == 0, "t5_drained", exp_q.size(), 0);

        // Asynchronous reset mid-WRITE
        do_reset();
        for (int w = 0; w < 8; w++) send(16'hC000 + 16'(w));
        wait_wr(2, 200, "t6_pre_writes");
        #1;
        check(fd_oe == 1'b1, "t6_in_write", fd_oe, 1);
        rst = 1'b1;
        #1;
        check(fd_oe == 1'b0, "t6_rst_fd_oe", fd_oe, 0);
        check({slrd_n, sloe_n, slwr_n, pktend_n} == 4'hF, "t6_rst_strobes", {slrd_n, sloe_n, slwr_n, pktend_n}, 4'hF);
        check(buf_level == 5'd0, "t6_rst_level", buf_level, 0);
        host_out.delete();
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        base = wr_cnt;
        for (int w = 0; w < 4; w++) send(16'hD000 + 16'(w));
        wait_wr(base + 4, 200, "t6_resume_writes");
        check(exp_q.size() == 0, "t6_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
